// File: rtl/audio_adc_deserializer.sv
// I2S capture front end: synchronises the codec ADC stream into CLOCK_50 and
// deserialises left/right words into stereo pairs with a valid/ready handshake.
module audio_adc_deserializer #(
   parameter int AUDIO_DATA_WIDTH = 32,
   parameter int SYNC_STAGES      = 2
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        AUD_BCLK,
   input  logic                        AUD_ADCLRCK,
   input  logic                        AUD_ADCDAT,
   output logic [AUDIO_DATA_WIDTH-1:0] data_audio_left,
   output logic [AUDIO_DATA_WIDTH-1:0] data_audio_right,
   output logic                        data_audio_valid,
   input  logic                        data_audio_ready,
   output logic                        overrun,
   input  logic                        clear_overrun
);

   // state    | meaning
   // IDLE     | waiting for a falling LRCK edge (start of a left word)
   // SKIP     | discarding the I2S one-bit delay after an LRCK edge
   // SHIFT    | shifting in data bits MSB first
   // WAIT_LR  | word complete, ignoring BCLK until the next LRCK edge
   typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_SHIFT, ST_WAIT_LR} state_t;

   localparam int W  = AUDIO_DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

   logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;
   logic                   bclk_prev_q, lrck_prev_q;
   logic                   bclk_s, lrck_s, dat_s;
   logic                   bclk_rise, lr_edge, lr_fall;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-2:0]    shift_q, shift_d;
   logic [W-1:0]    word;
   logic [W-1:0]    left_stage_q, left_stage_d;
   logic            chan_q, chan_d;
   logic            left_ok_q, left_ok_d;
   logic            drop_q, drop_d;
   logic            deliver;

   logic [W-1:0]    left_out_q, left_out_d;
   logic [W-1:0]    right_out_q, right_out_d;
   logic            valid_q, valid_d;
   logic            overrun_q, overrun_d;
   logic            overrun_set;

   assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
   assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
   assign dat_s     = dat_sync_q[SYNC_STAGES-1];
   assign bclk_rise = bclk_s & ~bclk_prev_q;
   assign lr_edge   = lrck_s ^ lrck_prev_q;
   assign lr_fall   = lr_edge & ~lrck_s;
   assign word      = {shift_q, dat_s};

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         dat_sync_q  <= '0;
         bclk_prev_q <= 1'b0;
         lrck_prev_q <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
         lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
         dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
         bclk_prev_q <= bclk_s;
         lrck_prev_q <= lrck_s;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_TOP;
         shift_q      <= '0;
         left_stage_q <= '0;
         chan_q       <= 1'b0;
         left_ok_q    <= 1'b0;
         drop_q       <= 1'b0;
         left_out_q   <= '0;
         right_out_q  <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         left_stage_q <= left_stage_d;
         chan_q       <= chan_d;
         left_ok_q    <= left_ok_d;
         drop_q       <= drop_d;
         left_out_q   <= left_out_d;
         right_out_q  <= right_out_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      left_stage_d = left_stage_q;
      chan_d       = chan_q;
      left_ok_d    = left_ok_q;
      drop_d       = drop_q;
      deliver      = 1'b0;
      if (!enable) begin
         state_d   = ST_IDLE;
         left_ok_d = 1'b0;
         drop_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // rising LRCK is ignored so every pair starts with left
               if (lr_fall) begin
                  state_d   = ST_SKIP;
                  chan_d    = 1'b0;
                  left_ok_d = 1'b0;
                  drop_d    = 1'b0;
               end
            end
            ST_SKIP, ST_SHIFT: begin
               if (lr_edge) begin
                  // short frame: an aborted left poisons the following right
                  state_d   = ST_SKIP;
                  drop_d    = ~chan_q;
                  chan_d    = lrck_s;
                  left_ok_d = 1'b0;
               end else if (bclk_rise) begin
                  if (state_q == ST_SKIP) begin
                     state_d = ST_SHIFT;
                     cnt_d   = CNT_TOP;
                  end else begin
                     shift_d = word[W-2:0];
                     cnt_d   = cnt_q - 1'b1;
                     if (cnt_q == '0) begin
                        state_d = ST_WAIT_LR;
                        cnt_d   = CNT_TOP;
                        if (!lrck_s) begin
                           left_stage_d = word;
                           left_ok_d    = 1'b1;
                        end else begin
                           deliver   = left_ok_q & ~drop_q;
                           left_ok_d = 1'b0;
                           drop_d    = 1'b0;
                        end
                     end
                  end
               end
            end
            ST_WAIT_LR: begin
               if (lr_edge) begin
                  state_d = ST_SKIP;
                  chan_d  = lrck_s;
                  if (!lrck_s) begin
                     left_ok_d = 1'b0;
                     drop_d    = 1'b0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      left_out_d  = left_out_q;
      right_out_d = right_out_q;
      valid_d     = valid_q;
      overrun_set = 1'b0;
      if (deliver) begin
         left_out_d  = left_stage_q;
         right_out_d = word;
         valid_d     = 1'b1;
         overrun_set = valid_q & ~data_audio_ready;
      end else if (valid_q && data_audio_ready) begin
         valid_d = 1'b0;
      end
      overrun_d = (overrun_q & ~clear_overrun) | overrun_set;
   end

   assign data_audio_left  = left_out_q;
   assign data_audio_right = right_out_q;
   assign data_audio_valid = valid_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Bench for audio_adc_deserializer: table of I2S frames, hand-written corner
// sequences, and random frames checked against a frame-level delivery rule.
module tb_audio_adc_deserializer;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n, enable, bclk, lrck, dat, ready, clr;
   logic [W-1:0]  dl, dr;
   logic          valid, ovr;

   int            total = 0;
   int            bad = 0;
   int            acc_cnt = 0;
   logic [W-1:0]  acc_l = '0, acc_r = '0;

   always #10 clk = ~clk;

   audio_adc_deserializer #(.AUDIO_DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .CLOCK_50(clk), .reset(rst_n), .enable(enable),
      .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
      .data_audio_left(dl), .data_audio_right(dr),
      .data_audio_valid(valid), .data_audio_ready(ready),
      .overrun(ovr), .clear_overrun(clr)
   );

   // accepted pairs, sampled mid-cycle where valid and ready are both settled
   always @(negedge clk) begin
      if (valid && ready) begin
         acc_cnt++;
         acc_l = dl;
         acc_r = dr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // I2S: rising edge 1 after the LR change is the delay slot, edges 2..33 carry MSB..LSB
   task automatic bclk_edges(input logic [W-1:0] d, input int first, input int last);
      for (int e = first; e <= last; e++) begin
         bclk = 1'b0;
         if (e >= 2 && e <= 33) dat = d[33-e];
         else if (e == 1)       dat = ~d[W-1];
         else                   dat = ~d[0];
         repeat (8) tick();
         bclk = 1'b1;
         repeat (8) tick();
      end
   endtask

   task automatic send_half(input logic ch, input logic [W-1:0] d, input int n);
      bclk = 1'b0;
      lrck = ch;
      bclk_edges(d, 1, n);
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int nl, input int nr);
      send_half(1'b0, l, nl);
      send_half(1'b1, r, nr);
      repeat (4) tick();
   endtask

   function automatic int pick_len();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(3, 32));
      return int'($urandom_range(33, 38));
   endfunction

   typedef struct {
      logic [W-1:0] l, r;
      int           nl, nr;
      int           exp_acc;
      logic [W-1:0] exp_l, exp_r;
   } vec_t;

   vec_t tbl[6];
   int   c0;

   initial begin
      tbl[0] = '{32'h12345678, 32'h80000001, 36, 36, 1, 32'h12345678, 32'h80000001};
      tbl[1] = '{32'hCAFEF00D, 32'hDEADBEEF, 21, 36, 0, 32'h12345678, 32'h80000001};
      tbl[2] = '{32'h11111111, 32'h22222222, 36, 36, 1, 32'h11111111, 32'h22222222};
      tbl[3] = '{32'h00000000, 32'hFFFFFFFF, 40, 34, 1, 32'h00000000, 32'hFFFFFFFF};
      tbl[4] = '{32'hAAAAAAAA, 32'h13572468, 36, 20, 0, 32'h00000000, 32'hFFFFFFFF};
      tbl[5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 33, 33, 1, 32'hA5A5A5A5, 32'h5A5A5A5A};

      rst_n = 1'b0; enable = 1'b1; bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
      ready = 1'b1; clr = 1'b0;
      repeat (5) tick();
      check("rst_left", dl, '0);
      check("rst_right", dr, '0);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_overrun", {31'b0, ovr}, 32'd0);
      rst_n = 1'b1;
      repeat (5) tick();

      // stream starts mid-right-word: nothing may come out of it
      send_half(1'b1, 32'hFFFF0000, 15);
      check("start_align_acc", 32'(acc_cnt), 32'd0);

      for (int i = 0; i < 6; i++) begin
         c0 = acc_cnt;
         send_frame(tbl[i].l, tbl[i].r, tbl[i].nl, tbl[i].nr);
         check($sformatf("tbl%0d_acc", i), 32'(acc_cnt - c0), 32'(tbl[i].exp_acc));
         check($sformatf("tbl%0d_left", i), dl, tbl[i].exp_l);
         check($sformatf("tbl%0d_right", i), dr, tbl[i].exp_r);
         check($sformatf("tbl%0d_valid", i), {31'b0, valid}, 32'd0);
         check($sformatf("tbl%0d_overrun", i), {31'b0, ovr}, 32'd0);
      end

      // back-pressure across two frames
      ready = 1'b0;
      c0 = acc_cnt;
      send_frame(32'hAAAA5555, 32'h5555AAAA, 36, 36);
      check("bp1_valid", {31'b0, valid}, 32'd1);
      check("bp1_overrun", {31'b0, ovr}, 32'd0);
      check("bp1_left", dl, 32'hAAAA5555);
      send_frame(32'h00000001, 32'hFFFFFFFF, 36, 36);
      check("bp2_left", dl, 32'h00000001);
      check("bp2_right", dr, 32'hFFFFFFFF);
      check("bp2_valid", {31'b0, valid}, 32'd1);
      check("bp2_overrun", {31'b0, ovr}, 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      check("bp_clr_overrun", {31'b0, ovr}, 32'd0);
      check("bp_clr_valid", {31'b0, valid}, 32'd1);
      ready = 1'b1;
      tick();
      check("bp_accept_valid", {31'b0, valid}, 32'd0);
      check("bp_acc", 32'(acc_cnt - c0), 32'd1);
      check("bp_acc_right", acc_r, 32'hFFFFFFFF);

      // enable dropped mid-left-word, restored before the word's end
      c0 = acc_cnt;
      send_half(1'b0, 32'h77777777, 12);
      enable = 1'b0;
      bclk_edges(32'h77777777, 13, 20);
      check("en_hold_left", dl, 32'h00000001);
      enable = 1'b1;
      bclk_edges(32'h77777777, 21, 36);
      send_half(1'b1, 32'h88888888, 36);
      repeat (4) tick();
      check("en_acc", 32'(acc_cnt - c0), 32'd0);
      check("en_hold_right", dr, 32'hFFFFFFFF);
      send_frame(32'h3C3C3C3C, 32'hC3C3C3C3, 36, 36);
      check("en_next_acc", 32'(acc_cnt - c0), 32'd1);
      check("en_next_left", acc_l, 32'h3C3C3C3C);
      check("en_next_right", acc_r, 32'hC3C3C3C3);

      // random frames against the rule: a pair appears iff both halves carry a full word
      for (int f = 0; f < 16; f++) begin
         logic [W-1:0] l, r;
         int nl, nr, exp_acc;
         l = $urandom; r = $urandom;
         nl = pick_len(); nr = pick_len();
         exp_acc = (nl >= 33 && nr >= 33) ? 1 : 0;
         c0 = acc_cnt;
         send_frame(l, r, nl, nr);
         check($sformatf("rnd%0d_acc(nl=%0d,nr=%0d)", f, nl, nr), 32'(acc_cnt - c0), 32'(exp_acc));
         if (exp_acc == 1) begin
            check($sformatf("rnd%0d_left", f), acc_l, l);
            check($sformatf("rnd%0d_right", f), acc_r, r);
         end
      end
      check("rnd_overrun", {31'b0, ovr}, 32'd0);

      // async reset mid-SHIFT with valid and overrun set
      ready = 1'b0;
      send_frame(32'h01020304, 32'h05060708, 36, 36);
      send_frame(32'h090A0B0C, 32'h0D0E0F10, 36, 36);
      check("pre_rst_overrun", {31'b0, ovr}, 32'd1);
      send_half(1'b0, 32'h12121212, 15);
      #3 rst_n = 1'b0;
      #1;
      check("arst_left", dl, '0);
      check("arst_right", dr, '0);
      check("arst_valid", {31'b0, valid}, 32'd0);
      check("arst_overrun", {31'b0, ovr}, 32'd0);
      tick();
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (3) tick();
      c0 = acc_cnt;
      send_half(1'b1, 32'h99999999, 36);
      send_frame(32'h0F0F0F0F, 32'hF0F0F0F0, 36, 36);
      check("post_rst_acc", 32'(acc_cnt - c0), 32'd1);
      check("post_rst_left", acc_l, 32'h0F0F0F0F);
      check("post_rst_right", acc_r, 32'hF0F0F0F0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/audio_adc_deserializer.md
Name: audio_adc_deserializer

Overview:
- Front-end capture stage of the audio path; sits directly upstream of the sample-conditioning stage.
- Receives the codec ADC serial stream in I2S format (bit clock, LR clock, serial data) and synchronises it into the CLOCK_50 domain.
- Deserialises left and right 32-bit samples and presents each stereo pair to the downstream stage with a valid/ready handshake.
- Flags overruns when the consumer falls behind.

Parameters:
- AUDIO_DATA_WIDTH, 32, sample width in bits per channel.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).

Ports:
- CLOCK_50  input  1  system clock; all logic is clocked on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable.
- AUD_BCLK  input  1  codec bit clock; asynchronous; period is at least 8 CLOCK_50 cycles.
- AUD_ADCLRCK  input  1  codec LR clock; low = left channel, high = right channel.
- AUD_ADCDAT  input  1  codec serial data, MSB first.
- data_audio_left  output  AUDIO_DATA_WIDTH  last complete left sample.
- data_audio_right  output  AUDIO_DATA_WIDTH  last complete right sample.
- data_audio_valid  output  1  stereo pair available.
- data_audio_ready  input  1  consumer accepts the pair.
- overrun  output  1  sticky flag: a pair was delivered while the previous one was unaccepted.
- clear_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both data outputs, data_audio_valid and overrun go to 0.
  - FSM goes to IDLE, bit counter goes to AUDIO_DATA_WIDTH-1, shift register clears, synchroniser flops clear.
- Synchronisation and edge detection:
  - BCLK, ADCLRCK and ADCDAT each pass through SYNC_STAGES flops.
  - One extra registered copy of synced BCLK and synced LRCK provides edge detection.
  - bclk_rise = previous 0, current 1. lr_edge = any change of synced LRCK.
  - All decisions below use synced signals only.
- FSM states: IDLE, SKIP, SHIFT, WAIT_LR.
  - IDLE: wait for a falling lr_edge (start of left channel), then go to SKIP. A rising edge is ignored, so every pair always starts with left.
  - SKIP: consume the first bclk_rise after the LR edge (I2S one-bit delay), then go to SHIFT with counter = AUDIO_DATA_WIDTH-1.
  - SHIFT: on each bclk_rise, shift synced ADCDAT into the LSB of the shift register and decrement the counter.
    - If the counter is 0 on that edge, the word is complete: latch it into the channel staging register selected by current LRCK, then go to WAIT_LR.
  - WAIT_LR: ignore extra BCLK edges until lr_edge.
    - Falling edge: go to SKIP and capture left.
    - Rising edge: go to SKIP and capture right.
- Short frame: an lr_edge while in SKIP or SHIFT aborts the current word.
  - The partial word is discarded and the state restarts at SKIP for the new channel.
  - If the aborted word was left, the next right word is also dropped: after completing it, go to WAIT_LR without delivering, so pairs never mix frames.
- Delivery:
  - One CLOCK_50 cycle after the bclk_rise that completes a right word (following a valid left word), load data_audio_left/right from the staging registers and set data_audio_valid=1.
  - Latency is exactly 1 cycle from that detected edge.
- Handshake:
  - data_audio_valid stays high until the cycle with data_audio_valid=1 and data_audio_ready=1; it deasserts on the next edge.
  - Data outputs are stable while valid is high and no new delivery occurs.
- Overrun: a delivery while valid=1 and ready=0 in that cycle overwrites both outputs, keeps valid=1 and sets overrun=1.
- Simultaneous events:
  - Delivery coincident with acceptance (valid=1, ready=1 in the delivery cycle) loads the new pair, keeps valid=1 and does not set overrun.
  - clear_overrun coincident with a new overrun leaves overrun=1 (set wins).
- enable=0:
  - FSM forces IDLE on the next edge and any partial word is discarded.
  - Outputs, valid and overrun hold their values, and the handshake continues to work.
  - Re-enabling waits for a fresh falling LRCK edge.
- Reset mid-frame: everything clears immediately; capture resumes at the next falling LRCK edge after release.

Test Plan:
- Nominal: BCLK = CLOCK_50/16, left 0x12345678, right 0x80000001, ready held 1 -> valid pulses 1 cycle, left=0x12345678, right=0x80000001, overrun=0.
- Back-pressure: ready=0 across two frames (0xAAAA5555/0x5555AAAA, then 0x00000001/0xFFFFFFFF) -> outputs show the second pair, valid=1, overrun=1; clear_overrun clears overrun, valid stays 1; ready=1 then drops valid next cycle.
- Short frame: LRCK toggles after 20 left bits, then a full right word 0xDEADBEEF -> no delivery; the next full pair 0x11111111/0x22222222 is delivered correctly.
- Start alignment: stimulus begins with LRCK high mid-right-word -> first delivered pair is the first complete left/right pair, with no partial data.
- enable dropped mid-left-word then restored -> no delivery from the interrupted frame; next full frame delivered correctly; prior outputs held throughout.
- Async reset asserted mid-SHIFT with valid=1 -> outputs, valid and overrun go to 0 without a clock edge; after release, the next full frame 0x0F0F0F0F/0xF0F0F0F0 is delivered correctly.
